data_mem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the 64-bit byte-addressed data memory.

---
 rtl/data_mem_arb_pkg.sv | 22 ++
 rtl/data_mem_arbiter_rr_arbiter2.sv | 26 ++
 rtl/data_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared types and constants for the data memory arbiter
//
// Contents:
//   state_t         FSM encoding IDLE / ACCESS / RESP
//   P0, P1          port identifiers (also the value stored in last_grant)
//   MEM_BYTES_DEF   default memory size in bytes
//   BYTES_PER_WORD  bytes moved by one access
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int MEM_BYTES_DEF  = 256;
  localparam int BYTES_PER_WORD = 8;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// rtl/data_mem_arbiter_rr_arbiter2.sv - two-way combinational arbiter
//
// Ports:
//   req        in   [1:0]  request per port (bit 0 = port 0)
//   last_grant in   1      port granted on the previous accept
//   fixed_prio in   1      1 = port 0 always wins a tie
//   gnt        out  [1:0]  one-hot grant, zero when nobody requests
module rr_arbiter2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // Only a tie needs a decision; a lone requester is granted directly.
    if (req == 2'b11) begin
      if (fixed_prio || (last_grant == P1)) gnt = 2'b01;
      else                                  gnt = 2'b10;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port sequencer in front of the 64-bit data memory
//
// Optional feature macro: DATA_MEM_ARB_CHECK_EN (alignment/range rejection).
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   pN_req_i/we_i/addr_i/wdata_i   request from port N (held until pN_gnt_o)
//   pN_gnt_o                combinational accept strobe
//   pN_rvalid_o             one-cycle response pulse
//   pN_rdata_o, pN_err_o    response payload, valid with pN_rvalid_o
//   mem_addr_o/mem_data_o   memory address / write data (hold outside ACCESS)
//   mem_read_o/mem_write_o  memory strobes, high only during ACCESS
//   mem_data_i              combinational read data from memory
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_BYTES  = MEM_BYTES_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  output logic              p0_err_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              p1_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam logic FIXED = (FIXED_PRIO != 0);

  state_t            state;
  logic              last_grant;
  logic              cmd_we;
  logic              cmd_port;
  logic              cmd_bad;
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_bad;

  logic [1:0]        arb_gnt;
  logic              accept;
  logic              win_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              acc_bad;

  rr_arbiter2 u_arb (
    .req        ({p1_req_i, p0_req_i}),
    .last_grant (last_grant),
    .fixed_prio (FIXED),
    .gnt        (arb_gnt)
  );

  // Grant is gated by rst_i so every output is low for the whole reset.
  assign accept    = !rst_i && (state != ACCESS) && (p0_req_i || p1_req_i);
  assign p0_gnt_o  = accept && arb_gnt[0];
  assign p1_gnt_o  = accept && arb_gnt[1];

  assign win_port  = arb_gnt[1] ? P1 : P0;
  assign sel_we    = win_port ? p1_we_i    : p0_we_i;
  assign sel_addr  = win_port ? p1_addr_i  : p0_addr_i;
  assign sel_wdata = win_port ? p1_wdata_i : p0_wdata_i;

`ifdef DATA_MEM_ARB_CHECK_EN
  // Misaligned or past the last whole word: never reaches the memory.
  assign acc_bad = (sel_addr[2:0] != 3'd0) ||
                   (sel_addr > ADDR_W'(MEM_BYTES - BYTES_PER_WORD));
`else
  assign acc_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_grant  <= P1;
      cmd_we      <= 1'b0;
      cmd_port    <= P0;
      cmd_bad     <= 1'b0;
      rvalid      <= 2'b00;
      rsp_rdata   <= '0;
      rsp_bad     <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
    end else begin
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      rvalid      <= 2'b00;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            cmd_we      <= sel_we;
            cmd_port    <= win_port;
            cmd_bad     <= acc_bad;
            last_grant  <= win_port;
            // Address/data registers double as the command; they stay put
            // until the next accept, which gives the "hold" behaviour.
            mem_addr_o  <= sel_addr;
            mem_data_o  <= sel_wdata;
            mem_read_o  <= !sel_we && !acc_bad;
            mem_write_o <= sel_we && !acc_bad;
            state       <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          rsp_rdata        <= (cmd_we || cmd_bad) ? '0 : mem_data_i;
          rsp_bad          <= cmd_bad;
          rvalid[cmd_port] <= 1'b1;
          state            <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_rvalid_o = rvalid[0];
  assign p1_rvalid_o = rvalid[1];
  assign p0_rdata_o  = rvalid[0] ? rsp_rdata : '0;
  assign p1_rdata_o  = rvalid[1] ? rsp_rdata : '0;
  assign p0_err_o    = rvalid[0] && rsp_bad;
  assign p1_err_o    = rvalid[1] && rsp_bad;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed table-driven bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: round-robin, backed by a 256-byte memory model.
  logic        a_p0_req = 0, a_p0_we = 0, a_p1_req = 0, a_p1_we = 0;
  logic [63:0] a_p0_addr = 0, a_p0_wdata = 0, a_p1_addr = 0, a_p1_wdata = 0;
  logic        a_p0_gnt, a_p0_rvalid, a_p0_err, a_p1_gnt, a_p1_rvalid, a_p1_err;
  logic [63:0] a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_data, a_mem_rdata;
  logic        a_mem_read, a_mem_write;

  // Instance B: fixed priority, memory read data tied off.
  logic        b_p0_req = 0, b_p1_req = 0;
  logic [63:0] b_zero = 64'h0;
  logic        b_p0_gnt, b_p0_rvalid, b_p0_err, b_p1_gnt, b_p1_rvalid, b_p1_err;
  logic [63:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_data;
  logic        b_mem_read, b_mem_write;

  data_mem_arbiter #(.FIXED_PRIO(0)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(a_p0_req), .p0_we_i(a_p0_we), .p0_addr_i(a_p0_addr), .p0_wdata_i(a_p0_wdata),
    .p0_gnt_o(a_p0_gnt), .p0_rvalid_o(a_p0_rvalid), .p0_rdata_o(a_p0_rdata), .p0_err_o(a_p0_err),
    .p1_req_i(a_p1_req), .p1_we_i(a_p1_we), .p1_addr_i(a_p1_addr), .p1_wdata_i(a_p1_wdata),
    .p1_gnt_o(a_p1_gnt), .p1_rvalid_o(a_p1_rvalid), .p1_rdata_o(a_p1_rdata), .p1_err_o(a_p1_err),
    .mem_addr_o(a_mem_addr), .mem_data_o(a_mem_data), .mem_read_o(a_mem_read),
    .mem_write_o(a_mem_write), .mem_data_i(a_mem_rdata)
  );

  data_mem_arbiter #(.FIXED_PRIO(1)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(b_p0_req), .p0_we_i(1'b0), .p0_addr_i(64'h20), .p0_wdata_i(b_zero),
    .p0_gnt_o(b_p0_gnt), .p0_rvalid_o(b_p0_rvalid), .p0_rdata_o(b_p0_rdata), .p0_err_o(b_p0_err),
    .p1_req_i(b_p1_req), .p1_we_i(1'b0), .p1_addr_i(64'h28), .p1_wdata_i(b_zero),
    .p1_gnt_o(b_p1_gnt), .p1_rvalid_o(b_p1_rvalid), .p1_rdata_o(b_p1_rdata), .p1_err_o(b_p1_err),
    .mem_addr_o(b_mem_addr), .mem_data_o(b_mem_data), .mem_read_o(b_mem_read),
    .mem_write_o(b_mem_write), .mem_data_i(b_zero)
  );

  function automatic logic [63:0] init_word(input int i);
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  logic [63:0] mem [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (a_mem_write) begin
      mem[a_mem_addr[7:3]] <= a_mem_data;
    end
  end
  assign a_mem_rdata = mem[a_mem_addr[7:3]];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  typedef struct {
    logic        r0, w0;
    logic [63:0] a0, d0;
    logic        r1;
    logic [63:0] a1;
    logic        g0, g1, v0, v1, mr, mw;
    logic [63:0] ma, rd;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];
  localparam logic [63:0] WD = 64'h1122334455667788;

  task automatic p1_read(input logic [63:0] addr, input logic exp_mr,
                         input logic exp_err, input logic [63:0] exp_rd);
    logic got;
    got = 1'b0;
    a_p1_req = 1'b1; a_p1_we = 1'b0; a_p1_addr = addr;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (a_p1_gnt) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk($sformatf("p1_gnt_%h", addr), 64'(got), 64'h1);
    @(posedge clk); #1;
    a_p1_req = 1'b0;
    @(negedge clk);
    chk($sformatf("mem_read_%h", addr), 64'(a_mem_read), 64'(exp_mr));
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("rvalid_%h", addr), 64'(a_p1_rvalid), 64'h1);
    chk($sformatf("err_%h", addr), 64'(a_p1_err), 64'(exp_err));
    chk($sformatf("rdata_%h", addr), a_p1_rdata, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    //        r0 w0 a0     d0    r1 a1     g0 g1 v0 v1 mr mw ma     rd
    // Both ports reading continuously: grants alternate from p0.
    vt[0]  = '{1, 0, 64'h20, 64'h0, 1, 64'h28, 1, 0, 0, 0, 0, 0, 64'h0,  64'h0};
    vt[1]  = '{1, 0, 64'h20, 64'h0, 1, 64'h28, 0, 0, 0, 0, 1, 0, 64'h20, 64'h0};
    vt[2]  = '{1, 0, 64'h20, 64'h0, 1, 64'h28, 0, 1, 1, 0, 0, 0, 64'h0,  init_word(4)};
    vt[3]  = '{1, 0, 64'h20, 64'h0, 1, 64'h28, 0, 0, 0, 0, 1, 0, 64'h28, 64'h0};
    vt[4]  = '{1, 0, 64'h20, 64'h0, 1, 64'h28, 1, 0, 0, 1, 0, 0, 64'h0,  init_word(5)};
    vt[5]  = '{1, 0, 64'h20, 64'h0, 1, 64'h28, 0, 0, 0, 0, 1, 0, 64'h20, 64'h0};
    vt[6]  = '{1, 0, 64'h20, 64'h0, 1, 64'h28, 0, 1, 1, 0, 0, 0, 64'h0,  init_word(4)};
    vt[7]  = '{1, 0, 64'h20, 64'h0, 1, 64'h28, 0, 0, 0, 0, 1, 0, 64'h28, 64'h0};
    vt[8]  = '{0, 0, 64'h0,  64'h0, 0, 64'h0,  0, 0, 0, 1, 0, 0, 64'h0,  init_word(5)};
    vt[9]  = '{0, 0, 64'h0,  64'h0, 0, 64'h0,  0, 0, 0, 0, 0, 0, 64'h0,  64'h0};
    // p0 write 0x10 then back-to-back read of the same word.
    vt[10] = '{1, 1, 64'h10, WD,    0, 64'h0,  1, 0, 0, 0, 0, 0, 64'h0,  64'h0};
    vt[11] = '{1, 0, 64'h10, 64'h0, 0, 64'h0,  0, 0, 0, 0, 0, 1, 64'h10, 64'h0};
    vt[12] = '{1, 0, 64'h10, 64'h0, 0, 64'h0,  1, 0, 1, 0, 0, 0, 64'h0,  64'h0};
    vt[13] = '{0, 0, 64'h0,  64'h0, 0, 64'h0,  0, 0, 0, 0, 1, 0, 64'h10, 64'h0};
    vt[14] = '{0, 0, 64'h0,  64'h0, 0, 64'h0,  0, 0, 1, 0, 0, 0, 64'h0,  WD};
    vt[15] = '{0, 0, 64'h0,  64'h0, 0, 64'h0,  0, 0, 0, 0, 0, 0, 64'h0,  64'h0};

    // Reset state.
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'({a_p0_gnt, a_p1_gnt}), 64'h0);
    chk("rst_rvalid", 64'({a_p0_rvalid, a_p1_rvalid}), 64'h0);
    chk("rst_strobes", 64'({a_mem_read, a_mem_write}), 64'h0);
    chk("rst_mem_addr", a_mem_addr, 64'h0);
    chk("rst_mem_data", a_mem_data, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      a_p0_req = vt[i].r0; a_p0_we = vt[i].w0; a_p0_addr = vt[i].a0; a_p0_wdata = vt[i].d0;
      a_p1_req = vt[i].r1; a_p1_we = 1'b0;     a_p1_addr = vt[i].a1; a_p1_wdata = 64'h0;
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), 64'(a_p0_gnt), 64'(vt[i].g0));
      chk($sformatf("v%0d_gnt1", i), 64'(a_p1_gnt), 64'(vt[i].g1));
      chk($sformatf("v%0d_rvalid0", i), 64'(a_p0_rvalid), 64'(vt[i].v0));
      chk($sformatf("v%0d_rvalid1", i), 64'(a_p1_rvalid), 64'(vt[i].v1));
      chk($sformatf("v%0d_mem_read", i), 64'(a_mem_read), 64'(vt[i].mr));
      chk($sformatf("v%0d_mem_write", i), 64'(a_mem_write), 64'(vt[i].mw));
      chk($sformatf("v%0d_rdata0", i), a_p0_rdata, vt[i].v0 ? vt[i].rd : 64'h0);
      chk($sformatf("v%0d_rdata1", i), a_p1_rdata, vt[i].v1 ? vt[i].rd : 64'h0);
      if (vt[i].mr || vt[i].mw) chk($sformatf("v%0d_mem_addr", i), a_mem_addr, vt[i].ma);
      @(posedge clk); #1;
    end

    // Fixed priority: six accesses all go to p0, p1 wins once p0 drops.
    b_p0_req = 1'b1; b_p1_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("fp%0d_gnt0", k), 64'(b_p0_gnt), (k % 2 == 0) ? 64'h1 : 64'h0);
      chk($sformatf("fp%0d_gnt1", k), 64'(b_p1_gnt), 64'h0);
      @(posedge clk); #1;
    end
    b_p0_req = 1'b0;
    @(negedge clk);
    chk("fp_drop_gnt1", 64'(b_p1_gnt), 64'h1);
    chk("fp_drop_gnt0", 64'(b_p0_gnt), 64'h0);
    @(posedge clk); #1;
    b_p1_req = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset during the ACCESS cycle of a p1 write.
    a_p1_req = 1'b1; a_p1_we = 1'b1; a_p1_addr = 64'h30; a_p1_wdata = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("abort_gnt1", 64'(a_p1_gnt), 64'h1);
    @(posedge clk); #1;
    a_p1_req = 1'b0;
    @(negedge clk);
    chk("abort_access_write", 64'(a_mem_write), 64'h1);
    #1 rst = 1'b1;
    a_p0_req = 1'b1; a_p0_we = 1'b0; a_p0_addr = 64'h20;
    a_p1_req = 1'b1; a_p1_we = 1'b0; a_p1_addr = 64'h28;
    #1;
    chk("abort_mem_write", 64'(a_mem_write), 64'h0);
    chk("abort_mem_addr", a_mem_addr, 64'h0);
    chk("abort_mem_data", a_mem_data, 64'h0);
    chk("abort_gnt", 64'({a_p0_gnt, a_p1_gnt}), 64'h0);
    chk("abort_rvalid", 64'({a_p0_rvalid, a_p1_rvalid}), 64'h0);
    @(posedge clk); #1;
    chk("abort_no_rvalid1", 64'(a_p1_rvalid), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tie_gnt0", 64'(a_p0_gnt), 64'h1);
    chk("post_rst_tie_gnt1", 64'(a_p1_gnt), 64'h0);
    @(posedge clk); #1;
    a_p0_req = 1'b0; a_p1_req = 1'b0;
    repeat (3) @(posedge clk); #1;

    // p1 reads at misaligned, last-word and out-of-range addresses.
`ifdef DATA_MEM_ARB_CHECK_EN
    p1_read(64'h0C,  1'b0, 1'b1, 64'h0);
    p1_read(64'hF8,  1'b1, 1'b0, init_word(31));
    p1_read(64'h100, 1'b0, 1'b1, 64'h0);
`else
    p1_read(64'h0C,  1'b1, 1'b0, init_word(1));
    p1_read(64'hF8,  1'b1, 1'b0, init_word(31));
    p1_read(64'h100, 1'b1, 1'b0, init_word(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
